// File: rtl/cfg_loader_ctrl_if.sv
// Serial configuration loader bus: the bit stream in, per-tile shift strobes
// and frame status out. The source drives the master side; the loader is the slave.
interface cfg_loader_ctrl_if #(
   parameter int N_TILES = 4
);
   logic               data_in;
   logic               data_valid;
   logic [N_TILES-1:0] tile_sel;
   logic               cfg_bit;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output data_in, data_valid,
      input  tile_sel, cfg_bit, busy, done, err
   );

   modport slave (
      input  data_in, data_valid,
      output tile_sel, cfg_bit, busy, done, err
   );
endinterface

// File: rtl/cfg_loader_ctrl.sv
// cfg_loader_ctrl: hunts for an A5 sync byte in a serial stream, then parses
// a 4-bit tile address, a LEN_W-bit payload length, and the payload. Each
// payload bit is steered to one tile chain as a single-cycle shift strobe.
// Optional feature macro CFG_PARITY_EN appends an even-parity bit to each
// frame, and a parity mismatch rejects the frame with err.
module cfg_loader_ctrl #(
   parameter int N_TILES = 4,
   parameter int LEN_W   = 12
) (
   input logic            clk,
   input logic            rst,
   cfg_loader_ctrl_if.slave bus
);
   // Field counter must reach 3 (address) and LEN_W-1 (length)
   localparam int CNT_W = $clog2((LEN_W > 4) ? LEN_W : 4);

`ifdef CFG_PARITY_EN
   typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD, PARITY} state_t;
`else
   typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD} state_t;
`endif

   state_t             state;
   logic [6:0]         win;      // last 7 hunt bits; live bit completes the byte
   logic [CNT_W-1:0]   fld_cnt;  // bits left in ADDR / LEN, minus one
   logic [3:0]         addr;
   logic [LEN_W-2:0]   len_sh;   // length bits gathered so far
   logic [LEN_W-1:0]   rem;      // payload bits still to come
`ifdef CFG_PARITY_EN
   logic               par;
`endif
   logic [N_TILES-1:0] tile_sel_r;
   logic               cfg_bit_r;
   logic               busy_r;
   logic               done_r;
   logic               err_r;

   logic [7:0]         win_nxt;
   logic [3:0]         addr_nxt;
   logic [LEN_W-1:0]   len_nxt;

   assign win_nxt  = {win, bus.data_in};
   assign addr_nxt = {addr[2:0], bus.data_in};
   assign len_nxt  = {len_sh, bus.data_in};

   assign bus.tile_sel = tile_sel_r;
   assign bus.cfg_bit  = cfg_bit_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.err      = err_r;

   // Frame parser: every transition is gated by data_valid, so gaps freeze
   // all state; strobes and pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= HUNT;
         win        <= '0;
         fld_cnt    <= '0;
         addr       <= '0;
         len_sh     <= '0;
         rem        <= '0;
`ifdef CFG_PARITY_EN
         par        <= 1'b0;
`endif
         tile_sel_r <= '0;
         cfg_bit_r  <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         tile_sel_r <= '0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         if (bus.data_valid) begin
            unique case (state)
               HUNT: begin
                  win <= win_nxt[6:0];
                  if (win_nxt == 8'hA5) begin
                     // Window is cleared so a later return to HUNT
                     // cannot match on bits left over from this frame.
                     win     <= '0;
                     state   <= ADDR;
                     busy_r  <= 1'b1;
                     fld_cnt <= CNT_W'(3);
`ifdef CFG_PARITY_EN
                     par     <= 1'b0;
`endif
                  end
               end
               ADDR: begin
                  addr <= addr_nxt;
                  if (fld_cnt == '0) begin
                     if (int'(addr_nxt) >= N_TILES) begin
                        err_r  <= 1'b1;
                        state  <= HUNT;
                        busy_r <= 1'b0;
                     end else begin
                        state   <= LEN;
                        fld_cnt <= CNT_W'(LEN_W - 1);
                     end
                  end else begin
                     fld_cnt <= fld_cnt - 1'b1;
                  end
               end
               LEN: begin
                  len_sh <= len_nxt[LEN_W-2:0];
                  if (fld_cnt == '0) begin
                     if (len_nxt == '0) begin
`ifdef CFG_PARITY_EN
                        state  <= PARITY;
`else
                        done_r <= 1'b1;
                        state  <= HUNT;
                        busy_r <= 1'b0;
`endif
                     end else begin
                        state <= PAYLOAD;
                        rem   <= len_nxt;
                     end
                  end else begin
                     fld_cnt <= fld_cnt - 1'b1;
                  end
               end
               PAYLOAD: begin
                  cfg_bit_r  <= bus.data_in;
                  tile_sel_r <= N_TILES'(1) << addr;
                  rem        <= rem - 1'b1;
`ifdef CFG_PARITY_EN
                  par        <= par ^ bus.data_in;
`endif
                  // rem is never zero here, so the decrement cannot wrap
                  if (rem == LEN_W'(1)) begin
`ifdef CFG_PARITY_EN
                     state  <= PARITY;
`else
                     done_r <= 1'b1;
                     state  <= HUNT;
                     busy_r <= 1'b0;
`endif
                  end
               end
`ifdef CFG_PARITY_EN
               PARITY: begin
                  if (bus.data_in == par) done_r <= 1'b1;
                  else                    err_r  <= 1'b1;
                  state  <= HUNT;
                  busy_r <= 1'b0;
               end
`endif
               default: begin
                  state  <= HUNT;
                  busy_r <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cfg_loader_ctrl.sv
// Bench for cfg_loader_ctrl: directed frames plus randomized frames checked
// against a stream-parsing reference model. Honors CFG_PARITY_EN like the RTL.
module tb_cfg_loader_ctrl;
   localparam int N_TILES = 4;
   localparam int LEN_W   = 12;
   localparam int HDR     = 8 + 4 + LEN_W;

   typedef bit bq_t[$];

   logic clk = 1'b0;
   logic rst;

   cfg_loader_ctrl_if #(.N_TILES(N_TILES)) bus();

   cfg_loader_ctrl #(.N_TILES(N_TILES), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Output monitor, sampled mid-cycle
   bit                 cap_bits[$];
   logic [N_TILES-1:0] cap_sel[$];
   int                 cap_cyc[$];
   int                 n_done, n_err, n_both, done_cyc, err_cyc, last_cyc;
   logic               err_busy;

   always @(negedge clk) begin
      if (bus.tile_sel != '0) begin
         cap_bits.push_back(bus.cfg_bit);
         cap_sel.push_back(bus.tile_sel);
         cap_cyc.push_back(cyc);
      end
      if (bus.done) begin n_done++; done_cyc = cyc; end
      if (bus.err)  begin n_err++;  err_cyc = cyc; err_busy = bus.busy; end
      if (bus.done && bus.err) n_both++;
   end

   task automatic clear_cap;
      cap_bits.delete(); cap_sel.delete(); cap_cyc.delete();
      n_done = 0; n_err = 0; n_both = 0; done_cyc = -1; err_cyc = -1; err_busy = 1'bx;
   endtask

   task automatic idle(input int n);
      bus.data_valid = 1'b0;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // Drive a bit stream; gap_n idle cycles after bits [gs,ge), otherwise random gaps up to rgap
   task automatic send_stream(input bq_t s, input int gs, input int ge, input int gap_n, input int rgap);
      foreach (s[i]) begin
         bus.data_in    = s[i];
         bus.data_valid = 1'b1;
         @(posedge clk);
         #1;
         last_cyc       = cyc;
         bus.data_valid = 1'b0;
         if (i >= gs && i < ge) idle(gap_n);
         else if (rgap > 0)     idle($urandom_range(0, rgap));
      end
   endtask

   // Frame builder: sync, address, length, payload, optional even parity (inverted when bad_par)
   task automatic build(input int tile, input int len, input bq_t pl, input bit bad_par, output bq_t s);
      logic [7:0]       syn;
      logic [3:0]       a;
      logic [LEN_W-1:0] l;
      bit               p;
      syn = 8'hA5; a = tile[3:0]; l = len[LEN_W-1:0]; p = 1'b0; s = {};
      for (int i = 7; i >= 0; i--)       s.push_back(syn[i]);
      for (int i = 3; i >= 0; i--)       s.push_back(a[i]);
      for (int i = LEN_W-1; i >= 0; i--) s.push_back(l[i]);
      foreach (pl[i]) begin s.push_back(pl[i]); p ^= pl[i]; end
`ifdef CFG_PARITY_EN
      s.push_back(p ^ bad_par);
`endif
   endtask

   // Reference model: parse a stream by the frame rules.
   // res: 0 = frame incomplete, 1 = done, 2 = err. sync_end = bits up to end of sync.
   task automatic model(input bq_t s, output int tile, output bq_t pl, output int res, output int sync_end);
      logic [7:0] w;
      int i, a, l, p;
      w = '0; i = 0; res = 0; sync_end = -1; tile = -1; pl = {};
      while (i < s.size()) begin
         w = {w[6:0], s[i]}; i++;
         if (w == 8'hA5) begin sync_end = i; break; end
      end
      if (sync_end < 0 || i + 4 > s.size()) return;
      a = 0;
      for (int k = 0; k < 4; k++) a = a * 2 + int'(s[i++]);
      tile = a;
      if (a >= N_TILES) begin res = 2; return; end
      if (i + LEN_W > s.size()) return;
      l = 0;
      for (int k = 0; k < LEN_W; k++) l = l * 2 + int'(s[i++]);
      if (i + l > s.size()) return;
      for (int k = 0; k < l; k++) pl.push_back(s[i++]);
`ifdef CFG_PARITY_EN
      if (i >= s.size()) return;
      p = 0;
      foreach (pl[k]) p = p + int'(pl[k]);
      res = (int'(s[i]) == p % 2) ? 1 : 2;
`else
      p = 0;
      res = 1 + p;
`endif
   endtask

   function automatic bq_t basic_payload();
      logic [7:0] v;
      bq_t q;
      v = 8'b1011_0010; q = {};
      for (int i = 7; i >= 0; i--) q.push_back(v[i]);
      return q;
   endfunction

   task automatic test_reset;
      @(negedge clk);
      checks++; if (bus.tile_sel !== '0) begin errors++; $display("FAIL reset_tile_sel got %b want 0", bus.tile_sel); end
      checks++; if (bus.cfg_bit !== 1'b0) begin errors++; $display("FAIL reset_cfg_bit got %b want 0", bus.cfg_bit); end
      checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
   endtask

   task automatic test_basic;
      bq_t s, pl;
      int bad, sel_bad;
      pl = basic_payload();
      build(2, 8, pl, 1'b0, s);
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(2);
      bad = 0; sel_bad = 0;
      foreach (cap_bits[i]) if (i < pl.size() && cap_bits[i] !== pl[i]) bad++;
      foreach (cap_sel[i]) if (cap_sel[i] !== 4'b0100) sel_bad++;
      checks++; if (cap_bits.size() != 8) begin errors++; $display("FAIL basic_shifts got %0d want 8", cap_bits.size()); end
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_cfg_bits got %0d wrong bits want 0", bad); end
      checks++; if (sel_bad != 0) begin errors++; $display("FAIL basic_tile_sel got %0d bad strobes want 0", sel_bad); end
      checks++; if (cap_cyc.size() == 8 && cap_cyc[7] - cap_cyc[0] != 7) begin errors++; $display("FAIL basic_contiguous got span %0d want 7", cap_cyc[7] - cap_cyc[0]); end
      checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL basic_status got done=%0d err=%0d want 1/0", n_done, n_err); end
      checks++; if (done_cyc != last_cyc) begin errors++; $display("FAIL basic_done_time got %0d want %0d", done_cyc, last_cyc); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
   endtask

`ifdef CFG_PARITY_EN
   task automatic test_parity_err;
      bq_t s;
      build(2, 8, basic_payload(), 1'b1, s);
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(2);
      checks++; if (cap_bits.size() != 8) begin errors++; $display("FAIL par_shifts got %0d want 8", cap_bits.size()); end
      checks++; if (n_err != 1 || n_done != 0) begin errors++; $display("FAIL par_status got done=%0d err=%0d want 0/1", n_done, n_err); end
      checks++; if (err_cyc != last_cyc) begin errors++; $display("FAIL par_err_time got %0d want %0d", err_cyc, last_cyc); end
      checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL par_busy got %b want 0", err_busy); end
   endtask
`endif

   task automatic test_zero_len;
      bq_t s, pl;
      pl = {};
      build(1, 0, pl, 1'b0, s);
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(2);
      checks++; if (cap_sel.size() != 0) begin errors++; $display("FAIL zlen_shifts got %0d want 0", cap_sel.size()); end
      checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL zlen_status got done=%0d err=%0d want 1/0", n_done, n_err); end
      checks++; if (done_cyc != last_cyc) begin errors++; $display("FAIL zlen_done_time got %0d want %0d", done_cyc, last_cyc); end
   endtask

   task automatic test_bad_addr;
      bq_t s, pl;
      pl = {};
      build(5, 0, pl, 1'b0, s);
      s = s[0:11];  // sync plus address only
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(3);
      checks++; if (n_err != 1 || n_done != 0) begin errors++; $display("FAIL addr_status got done=%0d err=%0d want 0/1", n_done, n_err); end
      checks++; if (err_cyc != last_cyc) begin errors++; $display("FAIL addr_err_time got %0d want %0d", err_cyc, last_cyc); end
      checks++; if (cap_sel.size() != 0) begin errors++; $display("FAIL addr_tile_sel got %0d strobes want 0", cap_sel.size()); end
      checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL addr_busy got %b want 0", err_busy); end
   endtask

   task automatic test_gaps;
      bq_t s, pl;
      int bad, sp_bad;
      pl = basic_payload();
      build(2, 8, pl, 1'b0, s);
      clear_cap();
      send_stream(s, HDR, HDR + 8, 3, 0);
      idle(2);
      bad = 0; sp_bad = 0;
      foreach (cap_bits[i]) if (i < pl.size() && cap_bits[i] !== pl[i]) bad++;
      for (int i = 1; i < cap_cyc.size(); i++) if (cap_cyc[i] - cap_cyc[i-1] != 4) sp_bad++;
      checks++; if (cap_bits.size() != 8 || bad != 0) begin errors++; $display("FAIL gap_cfg_bits got %0d shifts %0d wrong want 8/0", cap_bits.size(), bad); end
      checks++; if (sp_bad != 0) begin errors++; $display("FAIL gap_spacing got %0d bad gaps want 0", sp_bad); end
      checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL gap_status got done=%0d err=%0d want 1/0", n_done, n_err); end
   endtask

   // Leading 1010 partially matches, must restart inside itself to find A5
   task automatic test_overlap;
      bq_t s, f, pl;
      pl = basic_payload();
      build(3, 8, pl, 1'b0, f);
      s = {1'b1, 1'b0, 1'b1, 1'b0};
      s = {s, f};
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(2);
      checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL ovl_status got done=%0d err=%0d want 1/0", n_done, n_err); end
      checks++; if (cap_sel.size() != 8 || cap_sel[0] !== 4'b1000) begin errors++; $display("FAIL ovl_shifts got %0d want 8 on tile 3", cap_sel.size()); end
   endtask

   task automatic test_reset_mid;
      bq_t s, pl;
      int bad;
      pl = basic_payload();
      build(2, 8, pl, 1'b0, s);
      clear_cap();
      send_stream(s[0:HDR+2], 0, 0, 0, 0);
      rst = 1'b0; bus.data_valid = 1'b1; bus.data_in = 1'b1;
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
      @(negedge clk);
      checks++; if ({bus.tile_sel, bus.cfg_bit, bus.busy, bus.done, bus.err} !== '0)
         begin errors++; $display("FAIL rstmid_outputs got sel=%b bit=%b busy=%b done=%b err=%b want 0", bus.tile_sel, bus.cfg_bit, bus.busy, bus.done, bus.err); end
      rst = 1'b1;
      idle(2);
      checks++; if (n_done != 0 || n_err != 0) begin errors++; $display("FAIL rstmid_no_pulse got done=%0d err=%0d want 0/0", n_done, n_err); end
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(2);
      bad = 0;
      foreach (cap_bits[i]) if (i < pl.size() && cap_bits[i] !== pl[i]) bad++;
      checks++; if (n_done != 1 || cap_bits.size() != 8 || bad != 0) begin errors++; $display("FAIL rstmid_recover got done=%0d shifts=%0d wrong=%0d want 1/8/0", n_done, cap_bits.size(), bad); end
   endtask

   task automatic test_max_len;
      bq_t s, pl;
      int bad, l;
      l = (1 << LEN_W) - 1;
      pl = {};
      repeat (l) pl.push_back(bit'($urandom_range(0, 1)));
      build(0, l, pl, 1'b0, s);
      clear_cap();
      send_stream(s, 0, 0, 0, 0);
      idle(2);
      bad = 0;
      foreach (cap_bits[i]) if (i < pl.size() && cap_bits[i] !== pl[i]) bad++;
      checks++; if (cap_bits.size() != l || bad != 0) begin errors++; $display("FAIL maxlen_shifts got %0d shifts %0d wrong want %0d/0", cap_bits.size(), bad, l); end
      checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL maxlen_status got done=%0d err=%0d want 1/0", n_done, n_err); end
   endtask

   task automatic test_random;
      bq_t s, f, junk, pl, mpl;
      int tile, len, jl, mtile, res, se, bad, sel_bad;
      bit bad_par;
      for (int it = 0; it < 40; it++) begin
         tile = $urandom_range(0, N_TILES + 2);
         len  = $urandom_range(0, 24);
         bad_par = ($urandom_range(0, 3) == 0);
         pl = {};
         repeat (len) pl.push_back(bit'($urandom_range(0, 1)));
         build(tile, len, pl, bad_par, f);
         do begin
            junk = {};
            jl = $urandom_range(0, 10);
            repeat (jl) junk.push_back(bit'($urandom_range(0, 1)));
            s = {junk, f};
            model(s, mtile, mpl, res, se);
         end while (se != jl + 8);
         if (mtile >= N_TILES) s = s[0:se+3];
         clear_cap();
         send_stream(s, 0, 0, 0, 2);
         idle(3);
         bad = 0; sel_bad = 0;
         foreach (cap_bits[i]) if (i < mpl.size() && cap_bits[i] !== mpl[i]) bad++;
         foreach (cap_sel[i]) if (cap_sel[i] !== N_TILES'(1) << mtile) sel_bad++;
         checks++; if (cap_bits.size() != mpl.size() || bad != 0) begin errors++; $display("FAIL rnd%0d_bits got %0d shifts %0d wrong want %0d/0", it, cap_bits.size(), bad, mpl.size()); end
         checks++; if (sel_bad != 0) begin errors++; $display("FAIL rnd%0d_tile_sel got %0d bad strobes want 0 (tile %0d)", it, sel_bad, mtile); end
         checks++; if (n_done != (res == 1) || n_err != (res == 2)) begin errors++; $display("FAIL rnd%0d_status got done=%0d err=%0d want result %0d", it, n_done, n_err, res); end
         checks++; if (n_both != 0) begin errors++; $display("FAIL rnd%0d_exclusive got %0d overlaps want 0", it, n_both); end
      end
   endtask

   initial begin
      bus.data_in = 1'b0; bus.data_valid = 1'b0; rst = 1'b0;
      clear_cap();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b1;
      test_basic();
`ifdef CFG_PARITY_EN
      test_parity_err();
`endif
      test_zero_len();
      test_bad_addr();
      test_gaps();
      test_overlap();
      test_reset_mid();
      test_max_len();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
